// File: rtl/syn_counter_pkg.sv
// syn_counter_pkg: direction and boundary-mode constants shared by the counter blocks
package syn_counter_pkg;
  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam int WRAP = 0;
  localparam int SAT = 1;
endpackage

// File: rtl/tff_cell.sv
// tff_cell: T flip-flop with async active-high clear and complementary outputs
module tff_cell (
  input  logic clk,
  input  logic clr,
  input  logic t,
  output logic q,
  output logic q_bar
);
  always_ff @(posedge clk or posedge clr)
    if (clr) q <= 1'b0;
    else if (t) q <= ~q;
  assign q_bar = ~q;
endmodule

// File: rtl/syn_updown_counter.sv
// syn_updown_counter: loadable up/down counter over 0..MAX built from T flip-flops
module syn_updown_counter
  import syn_counter_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int MAX = 2**WIDTH-1,
  parameter int SATURATE = WRAP
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic             tc,
  output logic             ovf
);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam bit HOLD = SATURATE == SAT;
  logic at_max, at_zero;
  logic [WIDTH-1:0] up_q, dn_q, next_q;
  always_comb begin
    at_max = q == MAX_V;
    at_zero = q == '0;
    tc = en & ~load & (mode == DIR_DOWN ? at_zero : at_max);
    up_q = at_max ? (HOLD ? MAX_V : '0) : q + 1'b1;
    dn_q = at_zero ? (HOLD ? '0 : MAX_V) : q - 1'b1;
    next_q = load ? (d > MAX_V ? MAX_V : d) : en ? (mode == DIR_DOWN ? dn_q : up_q) : q;
  end
  // each cell flips exactly the bits that differ between q and next_q
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    tff_cell u_cell (
      .clk  (clk),
      .clr  (clr),
      .t    (next_q[i] ^ q[i]),
      .q    (q[i]),
      .q_bar(q_bar[i])
    );
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) ovf <= 1'b0;
    else ovf <= tc;
endmodule

// File: tb/tb_syn_updown_counter.sv
// tb_syn_updown_counter: wrap, saturate and MAX=1 counters checked against a behavioural model
module tb_syn_updown_counter;
  logic clk = 1'b0, clr = 1'b1, en = 1'b0, mode = 1'b0, load = 1'b0;
  logic [2:0] d = '0;
  logic [2:0] dq [3];
  logic [2:0] dqb [3];
  logic dtc [3];
  logic dovf [3];
  int checks = 0, errors = 0;
  int mq [3];
  int movf [3];
  int maxv [3] = '{5, 5, 1};
  int satv [3] = '{0, 1, 0};
  always #5 clk = ~clk;
  syn_updown_counter #(.WIDTH(3), .MAX(5), .SATURATE(0)) u_wrap (.clk(clk), .clr(clr), .en(en), .mode(mode), .load(load), .d(d), .q(dq[0]), .q_bar(dqb[0]), .tc(dtc[0]), .ovf(dovf[0]));
  syn_updown_counter #(.WIDTH(3), .MAX(5), .SATURATE(1)) u_sat (.clk(clk), .clr(clr), .en(en), .mode(mode), .load(load), .d(d), .q(dq[1]), .q_bar(dqb[1]), .tc(dtc[1]), .ovf(dovf[1]));
  syn_updown_counter #(.WIDTH(3), .MAX(1), .SATURATE(0)) u_m1 (.clk(clk), .clr(clr), .en(en), .mode(mode), .load(load), .d(d), .q(dq[2]), .q_bar(dqb[2]), .tc(dtc[2]), .ovf(dovf[2]));
  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask
  function automatic int nxt(input int k, input int q);
    if (load) return int'(d) > maxv[k] ? maxv[k] : int'(d);
    if (!en) return q;
    if (!mode) return q < maxv[k] ? q + 1 : (satv[k] != 0 ? maxv[k] : 0);
    return q > 0 ? q - 1 : (satv[k] != 0 ? 0 : maxv[k]);
  endfunction
  function automatic int mtc(input int k, input int q);
    return (en && !load && (mode ? q == 0 : q == maxv[k])) ? 1 : 0;
  endfunction
  always @(posedge clk or posedge clr)
    for (int k = 0; k < 3; k++) begin
      movf[k] <= clr ? 0 : mtc(k, mq[k]);
      mq[k] <= clr ? 0 : nxt(k, mq[k]);
    end
  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("m%0d_q", k), dq[k], mq[k]);
      chk($sformatf("m%0d_qbar", k), dqb[k], 7 - mq[k]);
      chk($sformatf("m%0d_tc", k), dtc[k], mtc(k, mq[k]));
      chk($sformatf("m%0d_ovf", k), dovf[k], movf[k]);
    end
  task automatic cyc(input logic e, input logic m, input logic l, input int dd);
    @(negedge clk);
    #1;
    en = e;
    mode = m;
    load = l;
    d = 3'(dd);
    @(posedge clk);
    #1;
  endtask
  int up_q0 [8] = '{1, 2, 3, 4, 5, 0, 1, 2};
  int up_o0 [8] = '{0, 0, 0, 0, 0, 1, 0, 0};
  int up_q1 [8] = '{1, 2, 3, 4, 5, 5, 5, 5};
  int up_o1 [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
  int up_q2 [8] = '{1, 0, 1, 0, 1, 0, 1, 0};
  int up_o2 [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int dn_q [3] = '{0, 5, 4};
  int dn_o [3] = '{0, 1, 0};
  int st_o [3] = '{0, 1, 1};
  initial begin
    #2;
    chk("rst_q", dq[0], 0);
    chk("rst_qbar", dqb[0], 7);
    chk("rst_ovf", dovf[0], 0);
    chk("rst_tc", dtc[0], 0);
    @(negedge clk);
    #1;
    clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 0);
      chk("up_wrap_q", dq[0], up_q0[i]);
      chk("up_wrap_ovf", dovf[0], up_o0[i]);
      chk("up_sat_q", dq[1], up_q1[i]);
      chk("up_sat_ovf", dovf[1], up_o1[i]);
      chk("m1_q", dq[2], up_q2[i]);
      chk("m1_ovf", dovf[2], up_o2[i]);
    end
    cyc(1'b0, 1'b0, 1'b1, 1);
    chk("load1_q", dq[0], 1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 0);
      chk("down_q", dq[0], dn_q[i]);
      chk("down_ovf", dovf[0], dn_o[i]);
      if (i == 0) chk("down_tc_at0", dtc[0], 1);
    end
    cyc(1'b0, 1'b0, 1'b1, 4);
    chk("sat_load4", dq[1], 4);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 0);
      chk("sat_up_q", dq[1], 5);
      chk("sat_up_ovf", dovf[1], st_o[i]);
    end
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("sat_down_from5", dq[1], 4);
    cyc(1'b0, 1'b1, 1'b1, 7);
    chk("load_clamp", dq[0], 5);
    chk("load_clamp_m1", dq[2], 1);
    cyc(1'b1, 1'b0, 1'b1, 2);
    chk("load_over_en", dq[0], 2);
    chk("load_over_en_tc", dtc[0], 0);
    cyc(1'b0, 1'b0, 1'b1, 3);
    chk("pre_clr_q", dq[0], 3);
    #2;
    clr = 1'b1;
    #1;
    chk("async_clr_q", dq[0], 0);
    chk("async_clr_qbar", dqb[0], 7);
    chk("async_clr_ovf", dovf[0], 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("clr_hold_q", dq[0], 0);
    @(negedge clk);
    #1;
    clr = 1'b0;
    cyc(1'b1, 1'b0, 1'b1, 3);
    chk("post_clr_load", dq[0], 3);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("post_clr_up", dq[0], 4);
    cyc(1'b0, 1'b0, 1'b0, 0);
    chk("hold_q", dq[0], 4);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/syn_updown_counter.md
SYN_UPDOWN_COUNTER -- requirements
Module: syn_updown_counter

Interface
REQ-001 Parameter WIDTH, default 3, sets the counter bit width (legal range 2..16).
REQ-002 Parameter MAX, default 2**WIDTH-1, sets the terminal count; the count range is 0..MAX, with 1 <= MAX <= 2**WIDTH-1.
REQ-003 Parameter SATURATE, default 0: 0 = wrap at the boundaries, 1 = hold at the boundaries.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 clr  input  1  reset; asynchronous, active-high.
REQ-006 en  input  1  count enable.
REQ-007 mode  input  1  count direction: 0 = up, 1 = down.
REQ-008 load  input  1  synchronous parallel-load strobe.
REQ-009 d  input  WIDTH  parallel-load value.
REQ-010 q  output  WIDTH  registered count value.
REQ-011 q_bar  output  WIDTH  bitwise complement of q.
REQ-012 tc  output  1  combinational terminal-count flag.
REQ-013 ovf  output  1  registered one-cycle boundary-event pulse.

Function
REQ-014 At each rising clk edge, operations take priority in this order: load, then en; with neither asserted, q holds.
REQ-015 On load=1, q takes the value d; if d > MAX, q takes MAX (clamp). The load ignores en and mode.
REQ-016 Up count (en=1, load=0, mode=0): if q < MAX, q becomes q+1; if q = MAX, q becomes 0 when SATURATE=0, or holds at MAX when SATURATE=1.
REQ-017 Down count (en=1, load=0, mode=1): if q > 0, q becomes q-1; if q = 0, q becomes MAX when SATURATE=0, or holds at 0 when SATURATE=1.
REQ-018 A mode change is sampled at the edge, like any other input; there is no direction-change latency or extra pipeline stage.
REQ-019 tc = en & ~load & ((mode=0 & q=MAX) | (mode=1 & q=0)); it is combinational, with no registered delay.
REQ-020 ovf is asserted for exactly the one cycle following an edge at which tc=1; otherwise ovf is 0.
REQ-021 ovf asserts at boundary events in both wrap and saturate modes.
REQ-022 With tc held high across consecutive edges (saturate, or MAX=1 wrapping), ovf stays high for those consecutive cycles.
REQ-023 q_bar always equals ~q, including during and after reset.
REQ-024 Arithmetic is unsigned, WIDTH bits wide, with no intermediate overflow beyond WIDTH; MAX comparisons are exact.
REQ-025 The counter is fully synchronous, with all bits updated on the same edge and no ripple clocking.

Reset
REQ-026 While clr=1, q=0, q_bar=all ones, and ovf=0, independent of clk.
REQ-027 The clr assertion takes effect immediately (asynchronously), including mid-count and mid-load.
REQ-028 On clr deassertion, the first counting edge starts from q=0; a load on that edge is honoured.
REQ-029 tc follows its equation during reset.

Structure
REQ-030 A shared package syn_counter_pkg holds the direction constants (DIR_UP=0, DIR_DOWN=1) and the mode constants (WRAP=0, SAT=1).
REQ-031 One sub-module, tff_cell (a T flip-flop with async active-high clr and outputs q and q_bar), is instantiated WIDTH times.
REQ-032 The per-bit toggle enables are derived combinationally from the next-state value, as next_q XOR q.

Verification (WIDTH=3, MAX=5 unless stated)
REQ-033 Apply clr=1, then release; drive en=1, mode=0 for 8 edges -> q = 1,2,3,4,5,0,1,2, with ovf high only in the cycle after 5->0.
REQ-034 From q=1, drive mode=1 for 3 edges -> q = 0,5,4, with tc=1 while q=0 and ovf pulsing once.
REQ-035 With SATURATE=1, start at q=4 and count up for 3 edges -> q = 5,5,5, with ovf high for 2 consecutive cycles.
REQ-036 With load=1, d=7 -> q=5 (clamped); with load=1, en=1, d=2 -> q=2 (load wins over en).
REQ-037 Assert clr asynchronously mid-cycle at q=3 -> q=0, q_bar=7, ovf=0 before the next edge.
REQ-038 With MAX=1, count up continuously -> q toggles between 0 and 1, with ovf high every other cycle.
